// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell iterated over WIDTH cycles, start/done handshake.
// Optional macro SERIAL_ADD_SUB_EN adds the op_sub port (A-B via ~B and carry-in of 1).
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             op_sub,
`endif
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q,   state_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic [WIDTH-1:0] shift_a_q, shift_a_d;
   logic [WIDTH-1:0] shift_b_q, shift_b_d;
   logic [WIDTH-1:0] work_q,    work_d;
   logic [WIDTH-1:0] sum_q,     sum_d;
   logic             carry_q,   carry_d;
   logic             msb_cin_q, msb_cin_d;
   logic             cout_q,    cout_d;
   logic             ovf_q,     ovf_d;

   logic             is_sub;
   logic             fa_x, fa_y, fa_c;
   logic             fa_out, fa_cout;

`ifdef SERIAL_ADD_SUB_EN
   assign is_sub = op_sub;
`else
   assign is_sub = 1'b0;
`endif

   // The single FullAdder cell (X, Y, C -> out, Cout) fed from the LSBs of the shift registers.
   assign fa_x    = shift_a_q[0];
   assign fa_y    = shift_b_q[0];
   assign fa_c    = carry_q;
   assign fa_out  = fa_x ^ fa_y ^ fa_c;
   assign fa_cout = (fa_x & fa_y) | (fa_c & (fa_x ^ fa_y));

   always_comb begin
      // NOTE: every *_d defaults to its *_q first so no path through the case infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_a_d = shift_a_q;
      shift_b_d = shift_b_q;
      work_d    = work_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      msb_cin_d = msb_cin_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               shift_a_d = a;
               shift_b_d = is_sub ? ~b : b;
               carry_d   = is_sub ? 1'b1 : cin;
               cnt_d     = '0;
               state_d   = S_RUN;
            end else begin
               state_d   = S_IDLE;
            end
         end

         S_RUN: begin
            carry_d   = fa_cout;
            shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
            shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
            work_d    = {fa_out, work_q[WIDTH-1:1]};
            cnt_d     = cnt_q + CW'(1);
            // Carry produced by bit WIDTH-2 is the carry into the MSB, needed for signed overflow.
            if (cnt_q == CNT_PENULT) begin
               msb_cin_d = fa_cout;
            end
            if (cnt_q == CNT_LAST) begin
               sum_d   = {fa_out, work_q[WIDTH-1:1]};
               cout_d  = fa_cout;
               ovf_d   = msb_cin_q ^ fa_cout;
               state_d = S_DONE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         shift_a_q <= '0;
         shift_b_q <= '0;
         work_q    <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         msb_cin_q <= 1'b0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_a_q <= shift_a_d;
         shift_b_q <= shift_b_d;
         work_q    <= work_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
         msb_cin_q <= msb_cin_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
      end
   end

   assign ready = (state_q != S_RUN);
   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign sum   = sum_q;
   assign cout  = cout_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: expected results pushed at accept, popped on each done pulse.
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } res_t;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
   } vec_t;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             cin   = 1'b0;
   logic [WIDTH-1:0] a     = '0;
   logic [WIDTH-1:0] b     = '0;
`ifdef SERIAL_ADD_SUB_EN
   logic             op_sub = 1'b0;
`endif
   logic             ready, busy, done, cout, ovf;
   logic [WIDTH-1:0] sum;

   res_t             exp_q[$];
   int               n_vec = 0;
   int               n_err = 0;
   logic [WIDTH-1:0] last_sum = '0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .cin    (cin),
`ifdef SERIAL_ADD_SUB_EN
      .op_sub (op_sub),
`endif
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .sum    (sum),
      .cout   (cout),
      .ovf    (ovf)
   );

   function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic cv, input logic sv);
      logic [WIDTH-1:0] bb;
      logic             c;
      logic [WIDTH:0]   full;
      res_t             r;
      bb     = sv ? ~bv : bv;
      c      = sv ? 1'b1 : cv;
      full   = {1'b0, av} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
      r.sum  = full[WIDTH-1:0];
      r.cout = full[WIDTH];
      r.ovf  = (av[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != av[WIDTH-1]);
      return r;
   endfunction

   // Drive one request at a negedge; returns at the negedge just after the accepting edge.
   task automatic accept(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic sv);
      a   = av;
      b   = bv;
      cin = cv;
`ifdef SERIAL_ADD_SUB_EN
      op_sub = sv;
`endif
      start = 1'b1;
      exp_q.push_back(model(av, bv, cv, sv));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Bounded wait for done; cyc = negedges advanced, bcyc = negedges seen with busy before done.
   task automatic wait_done(output int cyc, output int bcyc, output bit to);
      cyc  = 0;
      bcyc = 0;
      to   = 1'b0;
      for (int k = 0; k < 4 * WIDTH; k++) begin
         if (busy === 1'b1) bcyc++;
         @(negedge clk);
         cyc++;
         if (done === 1'b1) return;
      end
      to = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_vec++;
      if ({sum, cout, ovf, done, busy, ready} !== {{WIDTH{1'b0}}, 5'b00001}) begin
         n_err++;
         $display("FAIL reset_state: got sum=%h cout=%b ovf=%b done=%b busy=%b ready=%b, need 00/0/0/0/0/1",
                  sum, cout, ovf, done, busy, ready);
      end
      last_sum = '0;
   endtask

   task automatic test_add;
      vec_t vt[6];
      int   cyc, bcyc;
      bit   to;
      res_t e, got;
      vt[0] = '{8'h0F, 8'h01, 1'b0};
      vt[1] = '{8'hFF, 8'h01, 1'b0};
      vt[2] = '{8'h7F, 8'h00, 1'b1};
      vt[3] = '{8'h80, 8'h80, 1'b0};
      vt[4] = '{8'hA5, 8'h3C, 1'b1};
      vt[5] = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1))};
      foreach (vt[i]) begin
         accept(vt[i].a, vt[i].b, vt[i].cin, 1'b0);
         n_vec++;
         if (sum !== last_sum) begin
            n_err++;
            $display("FAIL add_hold[%0d]: sum during run got %h, need %h", i, sum, last_sum);
         end
         wait_done(cyc, bcyc, to);
         n_vec++;
         if (to) begin
            n_err++;
            $display("FAIL add_timeout[%0d]: no done within %0d cycles", i, 4 * WIDTH);
            void'(exp_q.pop_front());
         end else begin
            e   = exp_q.pop_front();
            got = {sum, cout, ovf};
            if (got !== e || cyc != WIDTH || bcyc != WIDTH) begin
               n_err++;
               $display("FAIL add[%0d]: got sum=%h cout=%b ovf=%b lat=%0d busy=%0d, need sum=%h cout=%b ovf=%b lat=%0d busy=%0d",
                        i, sum, cout, ovf, cyc, bcyc, e.sum, e.cout, e.ovf, WIDTH, WIDTH);
            end
            last_sum = e.sum;
         end
         @(negedge clk);
         n_vec++;
         if (done !== 1'b0 || ready !== 1'b1 || sum !== last_sum) begin
            n_err++;
            $display("FAIL add_pulse[%0d]: got done=%b ready=%b sum=%h, need done=0 ready=1 sum=%h",
                     i, done, ready, sum, last_sum);
         end
      end
   endtask

`ifdef SERIAL_ADD_SUB_EN
   task automatic test_sub;
      vec_t vt[3];
      int   cyc, bcyc;
      bit   to;
      res_t e, got;
      vt[0] = '{8'h05, 8'h07, 1'b0};
      vt[1] = '{8'h80, 8'h01, 1'b1};
      vt[2] = '{8'h30, 8'h30, 1'b0};
      foreach (vt[i]) begin
         accept(vt[i].a, vt[i].b, vt[i].cin, 1'b1);
         op_sub = 1'b0;
         wait_done(cyc, bcyc, to);
         n_vec++;
         if (to) begin
            n_err++;
            $display("FAIL sub_timeout[%0d]: no done within %0d cycles", i, 4 * WIDTH);
            void'(exp_q.pop_front());
         end else begin
            e   = exp_q.pop_front();
            got = {sum, cout, ovf};
            if (got !== e || cyc != WIDTH) begin
               n_err++;
               $display("FAIL sub[%0d]: got sum=%h cout=%b ovf=%b lat=%0d, need sum=%h cout=%b ovf=%b lat=%0d",
                        i, sum, cout, ovf, cyc, e.sum, e.cout, e.ovf, WIDTH);
            end
            last_sum = e.sum;
         end
         @(negedge clk);
      end
   endtask
`endif

   task automatic test_ignore_busy;
      int   cyc, bcyc, n_done;
      bit   to;
      res_t e, got;
      accept(8'h01, 8'h01, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      a     = 8'h55;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = '0;
      n_vec++;
      if (busy !== 1'b1 || sum !== last_sum) begin
         n_err++;
         $display("FAIL ignore_run: got busy=%b sum=%h, need busy=1 sum=%h", busy, sum, last_sum);
      end
      wait_done(cyc, bcyc, to);
      n_vec++;
      if (to) begin
         n_err++;
         $display("FAIL ignore_timeout: no done within %0d cycles", 4 * WIDTH);
         void'(exp_q.pop_front());
      end else begin
         e   = exp_q.pop_front();
         got = {sum, cout, ovf};
         if (got !== e) begin
            n_err++;
            $display("FAIL ignore_result: got sum=%h cout=%b ovf=%b, need sum=%h cout=%b ovf=%b",
                     sum, cout, ovf, e.sum, e.cout, e.ovf);
         end
         last_sum = e.sum;
      end
      n_done = 0;
      repeat (2 * WIDTH) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      n_vec++;
      if (n_done != 0) begin
         n_err++;
         $display("FAIL ignore_extra_done: got %0d extra done pulses, need 0", n_done);
      end
   endtask

   task automatic test_abort;
      int   cyc, bcyc, n_done;
      bit   to;
      res_t e, got;
      accept(8'h33, 8'h44, 1'b0, 1'b0);
      void'(exp_q.pop_back());
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      last_sum = '0;
      n_vec++;
      if ({sum, cout, ovf, done, busy, ready} !== {{WIDTH{1'b0}}, 5'b00001}) begin
         n_err++;
         $display("FAIL abort_state: got sum=%h cout=%b ovf=%b done=%b busy=%b ready=%b, need 00/0/0/0/0/1",
                  sum, cout, ovf, done, busy, ready);
      end
      n_done = 0;
      repeat (2 * WIDTH) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      n_vec++;
      if (n_done != 0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_no_done: got %0d done pulses busy=%b, need 0 and busy=0", n_done, busy);
      end
      accept(8'h02, 8'h03, 1'b0, 1'b0);
      wait_done(cyc, bcyc, to);
      n_vec++;
      if (to) begin
         n_err++;
         $display("FAIL abort_recover_timeout: no done within %0d cycles", 4 * WIDTH);
         void'(exp_q.pop_front());
      end else begin
         e   = exp_q.pop_front();
         got = {sum, cout, ovf};
         if (got !== e || cyc != WIDTH) begin
            n_err++;
            $display("FAIL abort_recover: got sum=%h cout=%b ovf=%b lat=%0d, need sum=%h cout=%b ovf=%b lat=%0d",
                     sum, cout, ovf, cyc, e.sum, e.cout, e.ovf, WIDTH);
         end
         last_sum = e.sum;
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int   cyc, bcyc;
      bit   to;
      res_t e, got;
      a     = 8'h10;
      b     = 8'h20;
      cin   = 1'b0;
      start = 1'b1;
      exp_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) begin
         wait_done(cyc, bcyc, to);
         n_vec++;
         if (to) begin
            n_err++;
            $display("FAIL b2b_timeout[%0d]: no done within %0d cycles", i, 4 * WIDTH);
            void'(exp_q.pop_front());
            break;
         end
         e   = exp_q.pop_front();
         got = {sum, cout, ovf};
         if (got !== e || cyc != WIDTH + 1) begin
            n_err++;
            $display("FAIL b2b[%0d]: got sum=%h cout=%b ovf=%b spacing=%0d, need sum=%h cout=%b ovf=%b spacing=%0d",
                     i, sum, cout, ovf, cyc, e.sum, e.cout, e.ovf, WIDTH + 1);
         end
         last_sum = e.sum;
         if (i < 2) exp_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
         else start = 1'b0;
      end
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL b2b_drain: got busy=%b pending=%0d, need busy=0 pending=0", busy, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_add();
`ifdef SERIAL_ADD_SUB_EN
      test_sub();
`endif
      test_ignore_busy();
      test_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
